argmax_seq_ctrl: RTL

//  Sequential classifier back end for the MLP output layer. Accepts N_CLASSES

---
 rtl/argmax_seq_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/argmax_seq_ctrl.sv
// ----------------------------------------------------------------------------
// argmax_seq_ctrl
//
// Sequential argmax back end for the MLP output layer. Scores arrive one per
// valid/ready transfer, in class order. One comparator tracks the running
// maximum and its class index. A one-cycle done pulse marks a final result.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active-high
//   start     begin a new classification (single-cycle pulse)
//   in_valid  in_data carries a score
//   in_data   score of the current class
//   in_ready  a score is accepted this cycle
//   busy      classification in progress
//   done      one-cycle pulse: argmax/max_val are valid and final
//   argmax    winning class index, held until the next run's first transfer
//   max_val   winning score, held until the next run's first transfer
//
// Build option
//   SIGNED_SCORE_EN  when defined, scores are two's complement and compared
//                    signed. Otherwise the compare is unsigned.
// ----------------------------------------------------------------------------
module argmax_seq_ctrl #(
    parameter int unsigned N_CLASSES = 10,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned IDX_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  argmax,
    output logic [DATA_W-1:0] max_val
);

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_CLASSES - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  argmax_q, argmax_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic              gt;

    // Strict compare: on a tie the earlier (lower) index keeps the lead.
`ifdef SIGNED_SCORE_EN
    assign gt = $signed(in_data) > $signed(max_q);
`else
    assign gt = in_data > max_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            argmax_q <= '0;
            max_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            argmax_q <= argmax_d;
            max_q    <= max_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        argmax_d = argmax_q;
        max_d    = max_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCollect;
                    cnt_d   = '0;
                end
            end
            StCollect: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    // The first score of a run always seeds the maximum.
                    if (cnt_q == '0 || gt) begin
                        max_d    = in_data;
                        argmax_d = cnt_q;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastIdx) begin
                        state_d = StDone;
                        cnt_d   = '0;
                    end
                end
            end
            StDone: begin
                done = 1'b1;
                if (start) begin
                    state_d = StCollect;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign argmax  = argmax_q;
    assign max_val = max_q;

endmodule
